// File: rtl/bus_owner_arbiter_pkg.sv
// bus_owner_arbiter_pkg
// Shared definitions for the bus owner arbiter slice.
//   SEL_W          : width of the owner index driving the 8-input bus muxes
//   DEF_MAX_HOLD   : default hold limit (only meaningful with BUS_ARB_TIMEOUT_EN)
//   DEF_TURNAROUND : default number of undriven cycles between two owners
//   arb_state_t    : arbiter state encoding
package bus_owner_arbiter_pkg;

  localparam int SEL_W          = 3;
  localparam int DEF_MAX_HOLD   = 16;
  localparam int DEF_TURNAROUND = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/bus_owner_arbiter_if.sv
// bus_owner_arbiter_if
// Request/grant bundle between the requesters and the bus owner arbiter.
//   req      : one bit per requester, held high while it wants or owns the bus
//   gnt      : one-hot grant, wired to the tristate output enables
//   sel      : index of the current (or last) owner for the bus muxes
//   bus_busy : high while any gnt bit is high
//   timeout  : one-cycle pulse when an owner is forced off the bus
// Modports: master = arbiter side, slave = requester side.
interface bus_owner_arbiter_if
  import bus_owner_arbiter_pkg::*;
#(
  parameter int N_REQ = 8
) ();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             bus_busy;
  logic             timeout;

  modport master (input req, output gnt, output sel, output bus_busy, output timeout);
  modport slave  (output req, input gnt, input sel, input bus_busy, input timeout);

endinterface

// File: rtl/bus_owner_arbiter_rr_pick.sv
// bus_owner_arbiter_rr_pick
// Combinational round-robin priority encoder.
//   req        : in  request vector
//   last_owner : in  index of the previous owner; the search starts just after it
//   found      : out at least one request is set
//   winner     : out index of the first set request, wrapping past N_REQ-1 to 0
module bus_owner_arbiter_rr_pick
  import bus_owner_arbiter_pkg::*;
#(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_owner,
  output logic             found,
  output logic [SEL_W-1:0] winner
);

  // Walk the requesters starting one past the last owner, so the previous
  // owner is considered last and gets the lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = last_owner;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(last_owner) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = SEL_W'((int'(last_owner) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/bus_owner_arbiter.sv
// bus_owner_arbiter
// Round-robin owner arbiter for the shared 32-bit tristate data bus.
// Guarantees TURNAROUND undriven cycles between two owners.
//   clock   : in  rising-edge clock
//   reset_n : in  asynchronous active-low reset
//   bus     : master modport of bus_owner_arbiter_if (req in; gnt, sel,
//             bus_busy, timeout out, all registered)
// Optional feature macro BUS_ARB_TIMEOUT_EN: hold counter, forced release
// after MAX_HOLD cycles when others are waiting, and the timeout pulse.
// Without it timeout stays 0 and an owner keeps the bus until it drops req.
module bus_owner_arbiter
  import bus_owner_arbiter_pkg::*;
#(
  parameter int N_REQ      = 8,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input logic                 clock,
  input logic                 reset_n,
  bus_owner_arbiter_if.master bus
);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2 || TURNAROUND < 1 || TURNAROUND > 3) begin : g_bad_params
    $error("bus_owner_arbiter: parameter out of range");
  end

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] gnt_r, gnt_n;
  logic [SEL_W-1:0] sel_r, sel_n;
  logic [SEL_W-1:0] last_owner, last_n;
  logic [1:0]       turn_cnt, turn_n;
  logic             busy_r, busy_n;
  logic             timeout_r, timeout_n;
  logic             found;
  logic [SEL_W-1:0] winner;
  logic             forced;

  bus_owner_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .found      (found),
    .winner     (winner)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Hold counter sits at zero outside GRANT, so it is already cleared on the
  // first grant cycle; it then counts up and saturates at MAX_HOLD-1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Pre-empt only when someone else is actually waiting; a lone owner keeps it.
  assign forced = (state == GRANT) && (hold_cnt == HOLD_MAX) && (|(bus.req & ~gnt_r));
`else
  assign forced = 1'b0;
`endif

  // Next-state and registered-output values. The grant is built from the
  // picker's winner index so gnt can only ever be zero or one-hot, and every
  // owner change passes through TURN with gnt at zero.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt_r;
    sel_n     = sel_r;
    last_n    = last_owner;
    turn_n    = turn_cnt;
    busy_n    = busy_r;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = N_REQ'(1) << winner;
          sel_n   = winner;
          busy_n  = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_r] || forced) begin
          state_n   = TURN;
          gnt_n     = '0;
          busy_n    = 1'b0;
          last_n    = sel_r;
          turn_n    = '0;
          timeout_n = forced && bus.req[sel_r];
        end
      end
      TURN: begin
        if (turn_cnt == 2'(TURNAROUND - 1)) begin
          if (found) begin
            state_n = GRANT;
            gnt_n   = N_REQ'(1) << winner;
            sel_n   = winner;
            busy_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          turn_n = turn_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State register; reset drops the grant immediately, and last_owner starts
  // at N_REQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt_r      <= '0;
      sel_r      <= '0;
      last_owner <= SEL_W'(N_REQ - 1);
      turn_cnt   <= '0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state      <= state_n;
      gnt_r      <= gnt_n;
      sel_r      <= sel_n;
      last_owner <= last_n;
      turn_cnt   <= turn_n;
      busy_r     <= busy_n;
      timeout_r  <= timeout_n;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.sel      = sel_r;
  assign bus.bus_busy = busy_r;
  assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// tb_bus_owner_arbiter
// Directed bench for bus_owner_arbiter (N_REQ=8, MAX_HOLD=4, TURNAROUND=1).
// Inputs change and outputs are sampled on the falling clock edge.
// With BUS_ARB_TIMEOUT_EN defined the forced-rotation and lone-requester
// sequences run; otherwise the no-preemption sequence runs.
module tb_bus_owner_arbiter;

  logic clock = 1'b0;
  logic reset_n;
  int   total_checks = 0;
  int   bad_checks   = 0;
  logic [7:0] exp_gnt;

  bus_owner_arbiter_if #(.N_REQ(8)) bus_if ();

  bus_owner_arbiter #(
    .N_REQ      (8),
    .MAX_HOLD   (4),
    .TURNAROUND (1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r);
    bus_if.req = r;
  endtask

  task automatic nextCycle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    bus_if.req = '0;
    nextCycle(2);
    checkOutput("reset_gnt", 32'(bus_if.gnt), 32'h00);
    checkOutput("reset_sel", 32'(bus_if.sel), 32'd0);
    checkOutput("reset_busy", 32'(bus_if.bus_busy), 32'd0);
    checkOutput("reset_timeout", 32'(bus_if.timeout), 32'd0);
    reset_n = 1'b1;

    // two simultaneous requests: 0 wins, then 2 after one idle cycle
    applyStimulus(8'h05);
    nextCycle(1);
    checkOutput("simul_gnt0", 32'(bus_if.gnt), 32'h01);
    checkOutput("simul_sel0", 32'(bus_if.sel), 32'd0);
    checkOutput("simul_busy", 32'(bus_if.bus_busy), 32'd1);
    applyStimulus(8'h04);
    nextCycle(1);
    checkOutput("simul_turn_gnt", 32'(bus_if.gnt), 32'h00);
    checkOutput("simul_turn_busy", 32'(bus_if.bus_busy), 32'd0);
    nextCycle(1);
    checkOutput("simul_gnt2", 32'(bus_if.gnt), 32'h04);
    checkOutput("simul_sel2", 32'(bus_if.sel), 32'd2);

    // hand over to requester 3
    applyStimulus(8'h08);
    nextCycle(1);
    checkOutput("hand3_turn", 32'(bus_if.gnt), 32'h00);
    nextCycle(1);
    checkOutput("hand3_gnt", 32'(bus_if.gnt), 32'h08);
    checkOutput("hand3_sel", 32'(bus_if.sel), 32'd3);

    // asynchronous reset mid-cycle while requester 3 owns the bus
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_gnt", 32'(bus_if.gnt), 32'h00);
    checkOutput("async_busy", 32'(bus_if.bus_busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    nextCycle(1);
    checkOutput("after_reset_gnt", 32'(bus_if.gnt), 32'h08);
    checkOutput("after_reset_sel", 32'(bus_if.sel), 32'd3);

    // wrap-around: 7 owns, releases with 0 pending, 0 must win
    applyStimulus(8'h80);
    nextCycle(1);
    checkOutput("wrap_turn", 32'(bus_if.gnt), 32'h00);
    nextCycle(1);
    checkOutput("wrap_gnt7", 32'(bus_if.gnt), 32'h80);
    checkOutput("wrap_sel7", 32'(bus_if.sel), 32'd7);
    applyStimulus(8'h81);
    nextCycle(1);
    checkOutput("wrap_hold7", 32'(bus_if.gnt), 32'h80);
    applyStimulus(8'h01);
    nextCycle(1);
    checkOutput("wrap_release", 32'(bus_if.gnt), 32'h00);
    nextCycle(1);
    checkOutput("wrap_gnt0", 32'(bus_if.gnt), 32'h01);
    checkOutput("wrap_sel0", 32'(bus_if.sel), 32'd0);

`ifndef BUS_ARB_TIMEOUT_EN
    // no pre-emption: owner 0 keeps the bus while 1 waits
    applyStimulus(8'h03);
    for (int c = 0; c < 20; c++) begin
      nextCycle(1);
      checkOutput("noto_gnt", 32'(bus_if.gnt), 32'h01);
      checkOutput("noto_timeout", 32'(bus_if.timeout), 32'd0);
      checkOutput("noto_busy", 32'(bus_if.bus_busy), 32'd1);
    end
`else
    // forced rotation with every requester asserted
    applyStimulus(8'h00);
    reset_n = 1'b0;
    nextCycle(1);
    reset_n = 1'b1;
    applyStimulus(8'hFF);
    for (int k = 0; k <= 8; k++) begin
      exp_gnt = 8'h01 << (k % 8);
      for (int c = 0; c < 4; c++) begin
        nextCycle(1);
        checkOutput("rot_gnt", 32'(bus_if.gnt), 32'(exp_gnt));
        checkOutput("rot_timeout_low", 32'(bus_if.timeout), 32'd0);
        checkOutput("rot_onehot", 32'($countones(bus_if.gnt) <= 1), 32'd1);
      end
      if (k < 8) begin
        nextCycle(1);
        checkOutput("rot_idle_gnt", 32'(bus_if.gnt), 32'h00);
        checkOutput("rot_timeout_pulse", 32'(bus_if.timeout), 32'd1);
      end
    end

    // lone requester is never pre-empted
    applyStimulus(8'h00);
    reset_n = 1'b0;
    nextCycle(1);
    reset_n = 1'b1;
    applyStimulus(8'h10);
    for (int c = 0; c < 100; c++) begin
      nextCycle(1);
      checkOutput("lone_gnt", 32'(bus_if.gnt), 32'h10);
      checkOutput("lone_timeout", 32'(bus_if.timeout), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
